// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported RAM between the instruction-fetch port and the
// data port of the pipelined datapath. The data port normally wins a
// conflict. A streak counter guarantees that instruction fetch is granted
// after at most STARVE_LIMIT back-to-back data grants. A watchdog abandons an
// access after TIMEOUT cycles without ram_ready, so a RAM that never answers
// cannot hang the pipeline.
//
// Each access takes at least two cycles: one IDLE cycle to decide the grant
// and at least one ACCESS cycle. Every access is followed by one IDLE
// turnaround cycle.
//
// Parameters:
//   STARVE_LIMIT  maximum consecutive data grants while an instruction
//                 request is pending (1..15)
//   TIMEOUT       ACCESS cycles without ram_ready before the access is
//                 abandoned (0 disables the watchdog)
//
// Optional build macro:
//   MEM_ARB_PERF_EN  adds the perf_igrants / perf_dgrants / perf_conflicts
//                    counter outputs
//
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   iREN, iaddr           instruction read request and address
//   iwait, iload          instruction handshake (low for one cycle) and data
//   dREN, dWEN            data read / write request
//   daddr, dstore         data address and write value
//   dwait, dload          data handshake (low for one cycle) and read data
//   ramREN, ramWEN        RAM strobes
//   ramaddr, ramstore     RAM address and write data
//   ramload, ram_ready    RAM read data and completion flag
//   err                   one-cycle pulse when an access is abandoned
//   perf_*                performance counters (MEM_ARB_PERF_EN only)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_igrants,
    output logic [31:0] perf_dgrants,
    output logic [31:0] perf_conflicts
`endif
);

    // The state also encodes the current grant: IDLE means no grant.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS_I = 2'd1,
        ACCESS_D = 2'd2
    } state_t;

    // The timer only has to count up to TIMEOUT-1.
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [3:0]    STREAK_MAX = 4'(STARVE_LIMIT);

    state_t        state;
    logic [3:0]    streak;
    logic [TW-1:0] timer;

    logic d_req;
    logic req_live;
    logic done;
    logic timed_out;

    assign d_req = dREN | dWEN;

    // The granted requester still asking. If it drops its request the
    // access is aborted, which takes precedence over completion and timeout.
    assign req_live = ((state == ACCESS_I) & iREN) |
                      ((state == ACCESS_D) & d_req);

    assign done = req_live & ram_ready;

    // ram_ready in the last allowed cycle still counts as a completion.
    generate
        if (TIMEOUT > 0) begin : g_watchdog
            assign timed_out = req_live & ~ram_ready & (timer == TIMER_LAST);
        end else begin : g_no_watchdog
            assign timed_out = 1'b0;
        end
    endgenerate

    assign err = timed_out;

    // RAM side and requester side outputs. The strobes follow the live
    // request so an abort drops them in the same cycle, and the wait lines
    // only drop when the live request completes. A write wins over a read
    // when both data strobes are high.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            ACCESS_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = ~(iREN & ram_ready);
            end
            ACCESS_D: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = ~(d_req & ram_ready);
            end
            default: ;
        endcase
    end

    // Grant decision, streak tracking and watchdog timer. The streak counts
    // data grants made while instruction fetch was waiting; once it reaches
    // STARVE_LIMIT the next conflict goes to instruction fetch, which
    // clears it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
            timer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (iREN && (!d_req || streak == STREAK_MAX)) begin
                        state  <= ACCESS_I;
                        streak <= '0;
                    end else if (d_req) begin
                        state <= ACCESS_D;
                        if (iREN) begin
                            streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ACCESS_I, ACCESS_D: begin
                    if (!req_live || done || timed_out) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer != TIMER_LAST) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Completion and conflict counters; they wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_igrants   <= '0;
            perf_dgrants   <= '0;
            perf_conflicts <= '0;
        end else begin
            if (state == ACCESS_I && done) begin
                perf_igrants <= perf_igrants + 32'd1;
            end
            if (state == ACCESS_D && done) begin
                perf_dgrants <= perf_dgrants + 32'd1;
            end
            if (state == IDLE && iREN && d_req) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter built with STARVE_LIMIT=4 and TIMEOUT=8.
// Inputs are changed 1 time unit after the rising edge and outputs are
// sampled a further time unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        err;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_igrants;
    logic [31:0] perf_dgrants;
    logic [31:0] perf_conflicts;
`endif

    logic ready_drv;
    logic auto_ready;

    int errors;
    int checks;

    // In auto mode the RAM answers in the same cycle a strobe is raised.
    assign ram_ready = auto_ready ? (ramREN | ramWEN) : ready_drv;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT(8)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload),
        .dREN(dREN),
        .dWEN(dWEN),
        .daddr(daddr),
        .dstore(dstore),
        .dwait(dwait),
        .dload(dload),
        .ramREN(ramREN),
        .ramWEN(ramWEN),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramload(ramload),
        .ram_ready(ram_ready),
        .err(err)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_igrants(perf_igrants),
        .perf_dgrants(perf_dgrants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (2) tick;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramREN: got %b expected 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramWEN: got %b expected 0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramaddr: got %h expected 0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramstore: got %h expected 0", ramstore); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("[TB] FAIL reset_wait: got iwait=%b dwait=%b expected 1 1", iwait, dwait); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("[TB] FAIL reset_load: got iload=%h dload=%h expected 0 0", iload, dload); end
        nRST = 1'b1;
        tick;
    endtask

    // Instruction read with ram_ready in the third ACCESS cycle.
    task automatic test_instr_fetch;
        iREN    = 1'b1;
        iaddr   = 32'h0000_0040;
        ramload = 32'h2002_0005;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL ifetch_idle_ramREN: got %b expected 0", ramREN); end
        tick;
        #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("[TB] FAIL ifetch_ramREN: got %b expected 1", ramREN); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("[TB] FAIL ifetch_ramaddr: got %h expected 00000040", ramaddr); end
        checks++; if (iwait !== 1'b1) begin errors++; $display("[TB] FAIL ifetch_wait_c1: got %b expected 1", iwait); end
        tick;
        #1;
        checks++; if (iwait !== 1'b1) begin errors++; $display("[TB] FAIL ifetch_wait_c2: got %b expected 1", iwait); end
        tick;
        ready_drv = 1'b1;
        #1;
        checks++; if (iwait !== 1'b0) begin errors++; $display("[TB] FAIL ifetch_wait_done: got %b expected 0", iwait); end
        checks++; if (iload !== 32'h2002_0005) begin errors++; $display("[TB] FAIL ifetch_iload: got %h expected 20020005", iload); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("[TB] FAIL ifetch_dwait: got %b expected 1", dwait); end
        tick;
        iREN      = 1'b0;
        ready_drv = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("[TB] FAIL ifetch_back_idle: got ramREN=%b iwait=%b iload=%h expected 0 1 0", ramREN, iwait, iload); end
    endtask

    // Write and instruction fetch together: data first, then instruction
    // after one turnaround cycle. dREN is also high to show write wins.
    task automatic test_data_priority;
        iREN   = 1'b1;
        iaddr  = 32'h0000_0044;
        dWEN   = 1'b1;
        dREN   = 1'b1;
        daddr  = 32'h0000_0080;
        dstore = 32'hDEAD_BEEF;
        tick;
        #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("[TB] FAIL prio_strobes: got ramWEN=%b ramREN=%b expected 1 0", ramWEN, ramREN); end
        checks++; if (ramstore !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL prio_ramstore: got %h expected deadbeef", ramstore); end
        checks++; if (ramaddr !== 32'h80) begin errors++; $display("[TB] FAIL prio_ramaddr: got %h expected 00000080", ramaddr); end
        ready_drv = 1'b1;
        #1;
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("[TB] FAIL prio_dwait: got dwait=%b iwait=%b expected 0 1", dwait, iwait); end
        tick;
        dWEN      = 1'b0;
        dREN      = 1'b0;
        ready_drv = 1'b0;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("[TB] FAIL prio_turnaround: got ramWEN=%b ramREN=%b expected 0 0", ramWEN, ramREN); end
        tick;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin errors++; $display("[TB] FAIL prio_igrant: got ramREN=%b ramaddr=%h expected 1 00000044", ramREN, ramaddr); end
        ready_drv = 1'b1;
        #1;
        checks++; if (iwait !== 1'b0) begin errors++; $display("[TB] FAIL prio_iwait: got %b expected 0", iwait); end
        tick;
        iREN      = 1'b0;
        ready_drv = 1'b0;
    endtask

    // Both requests held high with an instantly answering RAM.
    task automatic test_starvation;
        logic [9:0] seq;
        logic [9:0] seq_exp;
        int         n;
        seq     = '0;
        seq_exp = 10'b01111_01111;
        n       = 0;
        auto_ready = 1'b1;
        iREN  = 1'b1;
        dREN  = 1'b1;
        iaddr = 32'h0000_0100;
        daddr = 32'h0000_0200;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            tick;
            #1;
            checks++; if (iwait === 1'b0 && dwait === 1'b0) begin errors++; $display("[TB] FAIL starve_both_low: got iwait=%b dwait=%b expected not both 0", iwait, dwait); end
            if (dwait === 1'b0) begin
                seq[n] = 1'b1;
                n++;
            end else if (iwait === 1'b0) begin
                seq[n] = 1'b0;
                n++;
                checks++; if (dut.streak !== 4'd0) begin errors++; $display("[TB] FAIL starve_streak_clear: got %0d expected 0", dut.streak); end
            end
        end
        checks++; if (n !== 10) begin errors++; $display("[TB] FAIL starve_grant_count: got %0d expected 10", n); end
        checks++; if (seq !== seq_exp) begin errors++; $display("[TB] FAIL starve_order: got %b expected %b (bit0 first, 1=D)", seq, seq_exp); end
        tick;
        iREN       = 1'b0;
        dREN       = 1'b0;
        auto_ready = 1'b0;
        tick;
    endtask

    // RAM never answers: err on the 8th ACCESS cycle, then a re-grant.
    task automatic test_timeout;
        dREN  = 1'b1;
        daddr = 32'h0000_0300;
        for (int c = 1; c <= 8; c++) begin
            tick;
            #1;
            checks++; if (err !== (c == 8)) begin errors++; $display("[TB] FAIL timeout_err_c%0d: got %b expected %b", c, err, (c == 8)); end
            checks++; if (dwait !== 1'b1) begin errors++; $display("[TB] FAIL timeout_dwait_c%0d: got %b expected 1", c, dwait); end
        end
        tick;
        #1;
        checks++; if (ramREN !== 1'b0 || err !== 1'b0 || dwait !== 1'b1) begin errors++; $display("[TB] FAIL timeout_idle: got ramREN=%b err=%b dwait=%b expected 0 0 1", ramREN, err, dwait); end
        tick;
        #1;
        checks++; if (ramREN !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_regrant: got ramREN=%b err=%b expected 1 0", ramREN, err); end
        ready_drv = 1'b1;
        #1;
        checks++; if (dwait !== 1'b0) begin errors++; $display("[TB] FAIL timeout_regrant_done: got %b expected 0", dwait); end
        tick;
        dREN      = 1'b0;
        ready_drv = 1'b0;
        tick;
    endtask

    // Reset asserted in the second ACCESS_D cycle.
    task automatic test_reset_in_access;
        dREN  = 1'b1;
        iREN  = 1'b1;
        daddr = 32'h0000_0400;
        iaddr = 32'h0000_0048;
        tick;
        #1;
        checks++; if (dut.streak !== 4'd1) begin errors++; $display("[TB] FAIL rst_acc_streak_before: got %0d expected 1", dut.streak); end
        tick;
        nRST = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("[TB] FAIL rst_acc_ramREN_before: got %b expected 1", ramREN); end
        tick;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL rst_acc_strobes: got ramREN=%b ramWEN=%b expected 0 0", ramREN, ramWEN); end
        checks++; if (dwait !== 1'b1 || iwait !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL rst_acc_wait: got dwait=%b iwait=%b err=%b expected 1 1 0", dwait, iwait, err); end
        checks++; if (dut.streak !== 4'd0) begin errors++; $display("[TB] FAIL rst_acc_streak: got %0d expected 0", dut.streak); end
        dREN = 1'b0;
        iREN = 1'b0;
        nRST = 1'b1;
        tick;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("[TB] FAIL rst_acc_after: got ramREN=%b dwait=%b expected 0 1", ramREN, dwait); end
    endtask

`ifdef MEM_ARB_PERF_EN
    // Two conflicts (each D then I), one lone I, three lone D.
    task automatic test_perf;
        checks++; if (perf_igrants !== 0 || perf_dgrants !== 0 || perf_conflicts !== 0) begin errors++; $display("[TB] FAIL perf_reset: got %0d %0d %0d expected 0 0 0", perf_igrants, perf_dgrants, perf_conflicts); end
        auto_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iREN = 1'b1;
            dREN = 1'b1;
            tick;
            tick;
            dREN = 1'b0;
            tick;
            tick;
            iREN = 1'b0;
        end
        iREN = 1'b1;
        tick;
        tick;
        iREN = 1'b0;
        dREN = 1'b1;
        repeat (6) tick;
        dREN = 1'b0;
        tick;
        auto_ready = 1'b0;
        #1;
        checks++; if (perf_igrants !== 32'd3) begin errors++; $display("[TB] FAIL perf_igrants: got %0d expected 3", perf_igrants); end
        checks++; if (perf_dgrants !== 32'd5) begin errors++; $display("[TB] FAIL perf_dgrants: got %0d expected 5", perf_dgrants); end
        checks++; if (perf_conflicts !== 32'd2) begin errors++; $display("[TB] FAIL perf_conflicts: got %0d expected 2", perf_conflicts); end
    endtask
`endif

    initial begin
        errors     = 0;
        checks     = 0;
        nRST       = 1'b0;
        iREN       = 1'b0;
        iaddr      = '0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        ramload    = '0;
        ready_drv  = 1'b0;
        auto_ready = 1'b0;

        $display("[TB] starting mem_arbiter bench");
        test_reset;
        test_instr_fetch;
        test_data_priority;
        test_starvation;
        test_timeout;
        test_reset_in_access;
`ifdef MEM_ARB_PERF_EN
        test_perf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
